// File: rtl/bram_tetromino_reader.sv
// Port-0 read engine for the tetromino BRAM: bursts a contiguous word range out of the
// BRAM and presents it as a valid/ready stream through a 2-entry skid FIFO.
module bram_tetromino_reader #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 4,
  parameter int MEM_DEPTH = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [AWIDTH-1:0] i_base_addr,
  input  logic [AWIDTH:0]   i_len,
  output logic              o_req_ready,
  output logic [AWIDTH-1:0] o_bram_addr0,
  output logic              o_bram_ce0,
  output logic              o_bram_we0,
  output logic [DWIDTH-1:0] o_bram_d0,
  input  logic [DWIDTH-1:0] i_bram_q0,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  typedef struct packed {
    logic              last;
    logic [DWIDTH-1:0] data;
  } entry_t;

  logic [1:0]        state;
  logic [AWIDTH-1:0] base;
  logic [AWIDTH:0]   len;
  logic [AWIDTH:0]   issued;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        occ;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              done_q;
  entry_t            fifo [2];
  entry_t            head;

  logic              pop;
  logic              issue;
  logic              last_pop;
  logic              bad_req;
  logic [2:0]        proj;
  logic [AWIDTH+1:0] end_sum;

  assign head     = fifo[rd_ptr];
  assign o_valid  = (occ != 2'd0);
  assign o_data   = head.data;
  assign o_last   = o_valid & head.last;
  assign pop      = o_valid & i_ready;
  assign last_pop = pop & head.last;

  // Occupancy the FIFO will have once the outstanding read lands; a new read
  // is only safe if that leaves a free slot.
  assign proj  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign issue = (state == S_RUN) && (issued < len) && (proj < 3'd2);

  assign o_bram_ce0   = issue;
  assign o_bram_addr0 = issue ? (base + issued[AWIDTH-1:0]) : '0;
  assign o_bram_we0   = 1'b0;
  assign o_bram_d0    = '0;

  // Range check is done two bits wider than the address so it cannot wrap.
  assign end_sum = {2'b00, i_base_addr} + {1'b0, i_len};
  assign bad_req = (i_len == '0) || (end_sum > (AWIDTH+2)'(MEM_DEPTH));

  assign o_req_ready = (state == S_IDLE);
  assign o_err       = (state == S_ERR);
  assign o_done      = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      base          <= '0;
      len           <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      occ           <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          base   <= i_base_addr;
          len    <= i_len;
          issued <= '0;
          state  <= bad_req ? S_ERR : S_RUN;
        end
        S_ERR:  state <= S_IDLE;
        S_RUN:  if (last_pop) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (issue) issued <= issued + 1'b1;
      inflight      <= issue;
      inflight_last <= issue && (issued == len - 1'b1);
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      occ    <= occ + {1'b0, inflight} - {1'b0, pop};
      done_q <= last_pop;
    end
  end

  // Read data is only guaranteed for the single cycle after ce0, so it is captured then.
  always_ff @(posedge clk) begin
    if (inflight) fifo[wr_ptr] <= '{last: inflight_last, data: i_bram_q0};
  end

endmodule

// File: tb/tb_bram_tetromino_reader.sv
// Bench for bram_tetromino_reader: BRAM model with 1-cycle latency, stream monitor
// and a queue-based reference of which words each request must produce.
module tb_bram_tetromino_reader;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [AW:0]   i_len = '0;
  logic          i_ready = 1'b0;
  logic [DW-1:0] i_bram_q0 = '0;
  logic          o_req_ready, o_bram_ce0, o_bram_we0, o_valid, o_last, o_done, o_err;
  logic [AW-1:0] o_bram_addr0;
  logic [DW-1:0] o_bram_d0, o_data;

  logic [DW-1:0] mem [16];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  // Monitor logs (append-only)
  logic [DW:0] pop_q[$];
  int pop_cyc_q[$];
  int ce_q[$];
  int vrise_q[$];
  int done_cyc_q[$];
  int err_cyc_q[$];

  bram_tetromino_reader #(.DWIDTH(DW), .AWIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_len(i_len), .o_req_ready(o_req_ready), .o_bram_addr0(o_bram_addr0),
    .o_bram_ce0(o_bram_ce0), .o_bram_we0(o_bram_we0), .o_bram_d0(o_bram_d0),
    .i_bram_q0(i_bram_q0), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // BRAM port 0: data valid only the cycle after ce0, garbage otherwise
  always @(posedge clk) i_bram_q0 <= o_bram_ce0 ? mem[o_bram_addr0] : $urandom;

  task automatic monitor();
    int n_ce = 0, n_pop = 0;
    bit prev_stall = 0, prev_valid = 0, prev_last = 0;
    logic [DW-1:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        n_ce = 0; n_pop = 0; prev_stall = 0; prev_valid = 0;
      end else begin
        vectors++;
        if (n_ce - n_pop > 2) begin
          miscompares++;
          $display("FAIL occ_bound: outstanding=%0d required<=2 cyc=%0d", n_ce - n_pop, cyc);
        end
        if (prev_stall) begin
          vectors++;
          if ({o_valid, o_last, o_data} !== {1'b1, prev_last, prev_data}) begin
            miscompares++;
            $display("FAIL stall_hold: got v=%0b l=%0b d=%h required v=1 l=%0b d=%h",
                     o_valid, o_last, o_data, prev_last, prev_data);
          end
        end
        if (o_bram_ce0) begin ce_q.push_back(int'(o_bram_addr0)); n_ce++; end
        if (o_valid && i_ready) begin
          pop_q.push_back({o_last, o_data}); pop_cyc_q.push_back(cyc); n_pop++;
        end
        if (o_valid && !prev_valid) vrise_q.push_back(cyc);
        if (o_done) done_cyc_q.push_back(cyc);
        if (o_err) err_cyc_q.push_back(cyc);
        prev_stall = o_valid && !i_ready;
        prev_valid = o_valid;
        prev_data = o_data;
        prev_last = o_last;
      end
    end
  endtask

  task automatic do_start(input int b, input int l, output int e0);
    @(posedge clk); #1;
    i_start = 1'b1; i_base_addr = AW'(b); i_len = (AW+1)'(l);
    @(posedge clk); #1;
    e0 = cyc;
    i_start = 1'b0;
  endtask

  // Drives i_ready per mode until a done/err pulse is seen or the budget expires.
  task automatic run_wait(input int mode, input int stall_pct, input int max_cyc, output bit to);
    int d0 = done_cyc_q.size();
    int r0 = err_cyc_q.size();
    to = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      case (mode)
        0: i_ready = 1'b1;
        1: i_ready = pat[i % 8];
        default: i_ready = ($urandom_range(99) >= stall_pct);
      endcase
      @(negedge clk); #1;
      if (done_cyc_q.size() > d0 || err_cyc_q.size() > r0) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    vectors++;
    if ({o_valid, o_last, o_done, o_err, o_bram_ce0, o_bram_addr0, o_req_ready} !== {5'b0, 4'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_vals: v=%0b l=%0b d=%0b e=%0b ce=%0b a=%0d rdy=%0b required 0,0,0,0,0,0,1",
               o_valid, o_last, o_done, o_err, o_bram_ce0, o_bram_addr0, o_req_ready);
    end
    vectors++;
    if ({o_bram_we0, o_bram_d0} !== '0) begin
      miscompares++;
      $display("FAIL tied_write: we=%0b d=%h required 0", o_bram_we0, o_bram_d0);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({o_valid, o_bram_ce0, o_req_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL idle_after_reset: v=%0b ce=%0b rdy=%0b required 0,0,1", o_valid, o_bram_ce0, o_req_ready);
    end
  endtask

  task automatic test_full_burst();
    int p0 = pop_q.size(), c0 = ce_q.size(), v0 = vrise_q.size(), d0 = done_cyc_q.size();
    int e0; bit to;
    do_start(0, 10, e0);
    run_wait(0, 0, 40, to);
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL full_timeout: no done seen"); end
    vectors++;
    if (pop_q.size() - p0 !== 10) begin
      miscompares++; $display("FAIL full_count: got %0d words required 10", pop_q.size() - p0);
    end
    for (int i = 0; i < 10 && p0 + i < pop_q.size(); i++) begin
      logic [DW:0] exp = {(i == 9), mem[i]};
      vectors++;
      if (pop_q[p0+i] !== exp) begin
        miscompares++; $display("FAIL full_word%0d: got %h required %h", i, pop_q[p0+i], exp);
      end
      vectors++;
      if (pop_cyc_q[p0+i] !== e0 + 2 + i) begin
        miscompares++; $display("FAIL full_cycle%0d: got %0d required %0d", i, pop_cyc_q[p0+i], e0 + 2 + i);
      end
    end
    vectors++;
    if (vrise_q.size() <= v0 || vrise_q[v0] !== e0 + 2) begin
      miscompares++; $display("FAIL full_latency: first valid not at cycle %0d", e0 + 2);
    end
    vectors++;
    if (done_cyc_q.size() - d0 !== 1 || done_cyc_q[done_cyc_q.size()-1] !== e0 + 12) begin
      miscompares++; $display("FAIL full_done: pulses=%0d required 1 at cycle %0d", done_cyc_q.size() - d0, e0 + 12);
    end
    vectors++;
    if (ce_q.size() - c0 !== 10) begin
      miscompares++; $display("FAIL full_ce_count: got %0d required 10", ce_q.size() - c0);
    end
    for (int i = 0; i < 10 && c0 + i < ce_q.size(); i++) begin
      vectors++;
      if (ce_q[c0+i] !== i) begin
        miscompares++; $display("FAIL full_addr%0d: got %0d required %0d", i, ce_q[c0+i], i);
      end
    end
  endtask

  task automatic test_backpressure();
    int p0 = pop_q.size(), c0 = ce_q.size(), d0 = done_cyc_q.size();
    int e0; bit to;
    do_start(3, 4, e0);
    run_wait(1, 0, 60, to);
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL bp_timeout: no done seen"); end
    vectors++;
    if (pop_q.size() - p0 !== 4 || ce_q.size() - c0 !== 4) begin
      miscompares++; $display("FAIL bp_count: words=%0d reads=%0d required 4,4", pop_q.size() - p0, ce_q.size() - c0);
    end
    for (int i = 0; i < 4 && p0 + i < pop_q.size(); i++) begin
      logic [DW:0] exp = {(i == 3), mem[3+i]};
      vectors++;
      if (pop_q[p0+i] !== exp) begin
        miscompares++; $display("FAIL bp_word%0d: got %h required %h", i, pop_q[p0+i], exp);
      end
    end
    vectors++;
    if (done_cyc_q.size() - d0 !== 1) begin
      miscompares++; $display("FAIL bp_done: pulses=%0d required 1", done_cyc_q.size() - d0);
    end
  endtask

  task automatic test_err();
    int lens [2] = '{3, 0};
    for (int k = 0; k < 2; k++) begin
      int p0 = pop_q.size(), c0 = ce_q.size(), d0 = done_cyc_q.size(), r0 = err_cyc_q.size();
      int e0; bit to;
      do_start(8, lens[k], e0);
      run_wait(0, 0, 10, to);
      @(negedge clk);
      vectors++;
      if ({o_req_ready, o_err} !== 2'b10) begin
        miscompares++; $display("FAIL err_recover len=%0d: rdy=%0b err=%0b required 1,0", lens[k], o_req_ready, o_err);
      end
      repeat (2) @(posedge clk); #1;
      vectors++;
      if (err_cyc_q.size() - r0 !== 1 || err_cyc_q[err_cyc_q.size()-1] !== e0) begin
        miscompares++; $display("FAIL err_pulse len=%0d: pulses=%0d required 1 at cycle %0d", lens[k], err_cyc_q.size() - r0, e0);
      end
      vectors++;
      if ({ce_q.size() - c0, pop_q.size() - p0, done_cyc_q.size() - d0} !== {32'd0, 32'd0, 32'd0}) begin
        miscompares++; $display("FAIL err_side len=%0d: reads=%0d words=%0d dones=%0d required 0,0,0",
                                lens[k], ce_q.size() - c0, pop_q.size() - p0, done_cyc_q.size() - d0);
      end
    end
  endtask

  task automatic test_single();
    int p0 = pop_q.size(), c0 = ce_q.size(), d0 = done_cyc_q.size();
    int e0; bit to;
    do_start(9, 1, e0);
    run_wait(0, 0, 20, to);
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (pop_q.size() - p0 !== 1 || pop_q[pop_q.size()-1] !== {1'b1, 32'hA000_0009}) begin
      miscompares++; $display("FAIL single_word: count=%0d last=%h required 1 word 1a0000009", pop_q.size() - p0, pop_q[pop_q.size()-1]);
    end
    vectors++;
    if (ce_q.size() - c0 !== 1 || ce_q[ce_q.size()-1] !== 9) begin
      miscompares++; $display("FAIL single_addr: reads=%0d addr=%0d required 1 read at 9", ce_q.size() - c0, ce_q[ce_q.size()-1]);
    end
    vectors++;
    if (done_cyc_q.size() - d0 !== 1) begin
      miscompares++; $display("FAIL single_done: pulses=%0d required 1", done_cyc_q.size() - d0);
    end
  endtask

  task automatic test_ignore_start();
    int p0 = pop_q.size(), c0 = ce_q.size();
    int e0; bit to;
    do_start(0, 5, e0);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b1; i_base_addr = 4'd6; i_len = 5'd2;
    @(posedge clk); #1;
    i_start = 1'b0;
    run_wait(0, 0, 30, to);
    repeat (4) @(posedge clk); #1;
    vectors++;
    if (pop_q.size() - p0 !== 5 || ce_q.size() - c0 !== 5) begin
      miscompares++; $display("FAIL ign_count: words=%0d reads=%0d required 5,5", pop_q.size() - p0, ce_q.size() - c0);
    end
    for (int i = 0; i < 5 && p0 + i < pop_q.size(); i++) begin
      logic [DW:0] exp = {(i == 4), mem[i]};
      vectors++;
      if (pop_q[p0+i] !== exp || ce_q[c0+i] !== i) begin
        miscompares++; $display("FAIL ign_word%0d: got %h addr %0d required %h addr %0d", i, pop_q[p0+i], ce_q[c0+i], exp, i);
      end
    end
  endtask

  task automatic test_async_reset();
    int p0 = pop_q.size();
    int e0; bit to;
    do_start(0, 8, e0);
    i_ready = 1'b1;
    for (int i = 0; i < 30 && pop_q.size() < p0 + 3; i++) @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({o_valid, o_last, o_bram_ce0, o_done, o_req_ready} !== 5'b00001) begin
      miscompares++; $display("FAIL async_reset: v=%0b l=%0b ce=%0b d=%0b rdy=%0b required 0,0,0,0,1",
                              o_valid, o_last, o_bram_ce0, o_done, o_req_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    p0 = pop_q.size();
    begin
      int c0 = ce_q.size();
      do_start(2, 2, e0);
      run_wait(0, 0, 20, to);
      repeat (3) @(posedge clk); #1;
      vectors++;
      if (to !== 1'b0 || pop_q.size() - p0 !== 2 || ce_q.size() - c0 !== 2) begin
        miscompares++; $display("FAIL post_reset_count: to=%0b words=%0d reads=%0d required 0,2,2", to, pop_q.size() - p0, ce_q.size() - c0);
      end
      for (int i = 0; i < 2 && p0 + i < pop_q.size(); i++) begin
        logic [DW:0] exp = {(i == 1), mem[2+i]};
        vectors++;
        if (pop_q[p0+i] !== exp) begin
          miscompares++; $display("FAIL post_reset_word%0d: got %h required %h", i, pop_q[p0+i], exp);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int b, l, stall, e0;
      int p0 = pop_q.size(), c0 = ce_q.size(), d0 = done_cyc_q.size(), r0 = err_cyc_q.size();
      bit to, ok;
      if ($urandom_range(3) != 0) begin
        b = $urandom_range(DEPTH - 1); l = $urandom_range(DEPTH - b, 1);
      end else begin
        b = $urandom_range(15); l = $urandom_range(16);
      end
      ok = (l != 0) && (b + l <= DEPTH);
      stall = $urandom_range(70);
      do_start(b, l, e0);
      run_wait(2, stall, 400, to);
      repeat (2) @(posedge clk); #1;
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_timeout: b=%0d l=%0d", it, b, l); end
      vectors++;
      if ({pop_q.size() - p0, ce_q.size() - c0, done_cyc_q.size() - d0, err_cyc_q.size() - r0} !==
          {ok ? l : 0, ok ? l : 0, ok ? 32'd1 : 32'd0, ok ? 32'd0 : 32'd1}) begin
        miscompares++;
        $display("FAIL rnd%0d_counts b=%0d l=%0d: words=%0d reads=%0d dones=%0d errs=%0d required ok=%0b",
                 it, b, l, pop_q.size() - p0, ce_q.size() - c0, done_cyc_q.size() - d0, err_cyc_q.size() - r0, ok);
      end
      if (ok) begin
        for (int i = 0; i < l && p0 + i < pop_q.size() && c0 + i < ce_q.size(); i++) begin
          logic [DW:0] exp = {(i == l - 1), mem[b+i]};
          vectors++;
          if (pop_q[p0+i] !== exp || ce_q[c0+i] !== b + i) begin
            miscompares++; $display("FAIL rnd%0d_word%0d: got %h addr %0d required %h addr %0d",
                                    it, i, pop_q[p0+i], ce_q[c0+i], exp, b + i);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
    fork monitor(); join_none
    test_reset();
    test_full_burst();
    test_backpressure();
    test_err();
    test_single();
    test_ignore_start();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bram_tetromino_reader.md
# bram_tetromino_reader

Read-side engine for port 0 of the tetromino BRAM; the AXI4-lite slave writes the BRAM on port 1. On a start request it bursts a contiguous range of BRAM words out of port 0, absorbs the 1-cycle BRAM read latency, and presents the words to the game logic core as a valid/ready stream with `last` marking. It sits between `bram_tetromino` port 0 and the game logic core. A 2-entry output buffer provides full throughput and lossless backpressure.

## Interface
- DWIDTH, 32, BRAM word width
- AWIDTH, 4, BRAM address width
- MEM_DEPTH, 10, number of valid BRAM words (≤ 2^AWIDTH)

Ports:
- clk  in  1  clock; same clock as the BRAM port
- reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  request pulse; sampled only when o_req_ready=1
- i_base_addr  in  AWIDTH  first word address
- i_len  in  AWIDTH+1  word count
- o_req_ready  out  1  equals !busy
- o_bram_addr0  out  AWIDTH  BRAM port-0 address
- o_bram_ce0  out  1  BRAM port-0 read enable
- o_bram_we0  out  1  tied 0
- o_bram_d0  out  DWIDTH  tied 0
- i_bram_q0  in  DWIDTH  BRAM read data; valid exactly 1 cycle after ce0
- o_data  out  DWIDTH  stream data
- o_valid  out  1  stream valid
- i_ready  in  1  stream ready
- o_last  out  1  qualifies the final word of the burst
- o_done  out  1  1-cycle pulse when the final word is accepted
- o_err  out  1  1-cycle pulse when a request is rejected

## Operation
- States: IDLE, RUN, ERR.
- IDLE: when i_start=1, latch base and len, and zero the issue counter.
  - If len==0 or base+len > MEM_DEPTH (computed at AWIDTH+2 bits, no wrap), go to ERR.
  - Otherwise go to RUN.
- ERR: pulse o_err for one cycle, issue no BRAM access, return to IDLE.
- RUN, read issue: assert o_bram_ce0 with o_bram_addr0 = base + issued when issued < len and (occ + inflight − pop) < 2.
  - occ: buffer occupancy, 0..2.
  - inflight: 1 if ce0 was asserted in the previous cycle.
  - pop: o_valid & i_ready in the current cycle.
  - ce0 and addr0 are combinational from registered state.
- RUN, capture: one cycle after ce0, i_bram_q0 is written into the 2-entry FIFO. The design must not rely on q0 holding after that cycle.
- o_data/o_valid come from the FIFO head. o_last = o_valid & (head is word index len−1).
- When the last word is popped: pulse o_done in the following cycle and return to IDLE. The buffer is empty at that point.
- i_start while busy (RUN/ERR): ignored; latched parameters are unchanged.
- Addresses never wrap: the highest address issued is base+len−1 ≤ MEM_DEPTH−1.

## Timing
- Reset values: o_valid=0, o_last=0, o_done=0, o_err=0, o_bram_ce0=0, o_bram_addr0=0, o_req_ready=1. FIFO is empty, counters are 0, state is IDLE.
- Start sampled at edge E0:
  - first ce0 in the cycle after E0;
  - data captured at E2;
  - o_valid=1 after E2.
  - Start-to-first-valid latency is 2 cycles.
- With i_ready held at 1, words stream one per cycle with no bubbles. A burst of length N completes in N+2 cycles after E0, and o_done is high in the cycle after the last handshake.
- o_err is high in the cycle after E0.
- o_data and o_last must stay stable while o_valid=1 and i_ready=0.
- No ce0 is issued once issued==len.
- Asynchronous reset mid-burst: outputs return to reset values immediately. In-flight and buffered data are discarded. The next start after reset release works normally.

## Test plan
- Preload mem[i]=0xA000_0000+i. Start base=0, len=10, i_ready=1 → o_data 0xA0000000..0xA0000009 on 10 consecutive cycles; first valid 2 cycles after start; o_last only on 0xA0000009; o_done pulses once.
- Start base=3, len=4, i_ready pattern 1,0,0,1,0,1,1,… → exactly mem[3..6] in order, no duplicates or drops; occ+inflight never exceeds 2; data held stable while stalled.
- Start base=8, len=3 → o_err pulse 1 cycle after start; no ce0; o_req_ready=1 next cycle. Repeat with len=0 → same result.
- Start base=9, len=1 → single word 0xA0000009 with o_last=1; o_done pulse; the only ce0 issued has addr0=9.
- Start base=0, len=5; pulse i_start with base=6 mid-burst → the second request is ignored; output is mem[0..4] only.
- Start base=0, len=8; assert reset_n=0 after the 3rd word → o_valid and o_bram_ce0 drop asynchronously; after release, start base=2, len=2 → outputs mem[2], mem[3] only.
